// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - digit widths and BCD limits shared by the setting stage and time_counter
package clock_pkg;

    localparam int HL_W = 2;
    localparam int HR_W = 4;
    localparam int ML_W = 3;
    localparam int MR_W = 4;

    localparam logic [ML_W-1:0] MAX_TENS_MIN_SEC     = 3'd5;
    localparam logic [MR_W-1:0] MAX_UNITS            = 4'd9;
    localparam logic [HL_W-1:0] MAX_TENS_HOUR        = 2'd2;
    localparam logic [HR_W-1:0] MAX_UNITS_HOUR_AT_20 = 4'd3;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - one-second prescaler with clear/hold and a terminal-count pulse
module tick_gen #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tc
);

    localparam int              CW   = $clog2(TICKS_PER_SEC);
    localparam logic [CW-1:0]   LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    // tc is combinational so the digits advance on the same edge the prescaler wraps
    assign tc     = w_last & ~clr & ~hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (!hold) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/time_counter.sv
// rtl/time_counter.sv - BCD HH:MM:SS time-of-day counter with load/pause; SECONDS_OUT_EN exposes seconds digits
module time_counter
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic            pause,
    input  logic [HL_W-1:0] i_hours_left,
    input  logic [HR_W-1:0] i_hours_right,
    input  logic [ML_W-1:0] i_minutes_left,
    input  logic [MR_W-1:0] i_minutes_right,
    output logic [HL_W-1:0] o_hours_left,
    output logic [HR_W-1:0] o_hours_right,
    output logic [ML_W-1:0] o_minutes_left,
    output logic [MR_W-1:0] o_minutes_right,
`ifdef SECONDS_OUT_EN
    output logic [ML_W-1:0] o_seconds_left,
    output logic [MR_W-1:0] o_seconds_right,
`endif
    output logic            sec_tick,
    output logic            min_tick,
    output logic            day_tick,
    output logic            load_err
);

    logic [HL_W-1:0] r_hl;
    logic [HR_W-1:0] r_hr;
    logic [ML_W-1:0] r_ml;
    logic [MR_W-1:0] r_mr;
    logic [ML_W-1:0] r_sl;
    logic [MR_W-1:0] r_sr;
    logic            r_sec_tick;
    logic            r_min_tick;
    logic            r_day_tick;
    logic            r_load_err;

    logic w_tc;
    logic w_load_ok;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hour_wrap;

    tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (load_en),
        .hold (pause),
        .tc   (w_tc)
    );

    assign w_load_ok = (i_hours_left    <= MAX_TENS_HOUR)
                    && (i_hours_right   <= MAX_UNITS)
                    && (i_minutes_left  <= MAX_TENS_MIN_SEC)
                    && (i_minutes_right <= MAX_UNITS)
                    && !((i_hours_left == MAX_TENS_HOUR) && (i_hours_right > MAX_UNITS_HOUR_AT_20));

    assign w_sec_wrap  = (r_sl == MAX_TENS_MIN_SEC) && (r_sr == MAX_UNITS);
    assign w_min_wrap  = (r_ml == MAX_TENS_MIN_SEC) && (r_mr == MAX_UNITS);
    assign w_hour_wrap = (r_hl == MAX_TENS_HOUR) && (r_hr == MAX_UNITS_HOUR_AT_20);

    // w_tc is already masked by load_en and pause, so ticks follow it directly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sec_tick <= 1'b0;
            r_min_tick <= 1'b0;
            r_day_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= w_tc;
            r_min_tick <= w_tc & w_sec_wrap;
            r_day_tick <= w_tc & w_sec_wrap & w_min_wrap & w_hour_wrap;
            r_load_err <= load_en & ~w_load_ok;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hl <= '0;
            r_hr <= '0;
            r_ml <= '0;
            r_mr <= '0;
            r_sl <= '0;
            r_sr <= '0;
        end else if (load_en) begin
            if (w_load_ok) begin
                r_hl <= i_hours_left;
                r_hr <= i_hours_right;
                r_ml <= i_minutes_left;
                r_mr <= i_minutes_right;
                r_sl <= '0;
                r_sr <= '0;
            end
        end else if (w_tc) begin
            if (r_sr == MAX_UNITS) begin
                r_sr <= '0;
                if (r_sl == MAX_TENS_MIN_SEC) begin
                    r_sl <= '0;
                    if (r_mr == MAX_UNITS) begin
                        r_mr <= '0;
                        if (r_ml == MAX_TENS_MIN_SEC) begin
                            r_ml <= '0;
                            // hours units wrap at 3 in the twenties, at 9 otherwise
                            if (w_hour_wrap) begin
                                r_hl <= '0;
                                r_hr <= '0;
                            end else if (r_hr == MAX_UNITS) begin
                                r_hr <= '0;
                                r_hl <= r_hl + 2'd1;
                            end else begin
                                r_hr <= r_hr + 4'd1;
                            end
                        end else begin
                            r_ml <= r_ml + 3'd1;
                        end
                    end else begin
                        r_mr <= r_mr + 4'd1;
                    end
                end else begin
                    r_sl <= r_sl + 3'd1;
                end
            end else begin
                r_sr <= r_sr + 4'd1;
            end
        end
    end

    assign o_hours_left    = r_hl;
    assign o_hours_right   = r_hr;
    assign o_minutes_left  = r_ml;
    assign o_minutes_right = r_mr;
    assign sec_tick        = r_sec_tick;
    assign min_tick        = r_min_tick;
    assign day_tick        = r_day_tick;
    assign load_err        = r_load_err;

`ifdef SECONDS_OUT_EN
    assign o_seconds_left  = r_sl;
    assign o_seconds_right = r_sr;
`else
    // seconds remain internal; they still drive the minute carry and ticks
`endif

endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - directed self-checking bench for time_counter with TICKS_PER_SEC=4
module tb_time_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_en = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] i_hl = '0;
    logic [3:0] i_hr = '0;
    logic [2:0] i_ml = '0;
    logic [3:0] i_mr = '0;
    logic [1:0] o_hl;
    logic [3:0] o_hr;
    logic [2:0] o_ml;
    logic [3:0] o_mr;
`ifdef SECONDS_OUT_EN
    logic [2:0] o_sl;
    logic [3:0] o_sr;
`endif
    logic       sec_tick, min_tick, day_tick, load_err;
    logic [12:0] w_hhmm;

    int n_tests = 0;
    int n_fail  = 0;
    int n_sec = 0, n_min = 0, n_day = 0, n_all = 0;

    time_counter #(.TICKS_PER_SEC(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .load_en         (load_en),
        .pause           (pause),
        .i_hours_left    (i_hl),
        .i_hours_right   (i_hr),
        .i_minutes_left  (i_ml),
        .i_minutes_right (i_mr),
        .o_hours_left    (o_hl),
        .o_hours_right   (o_hr),
        .o_minutes_left  (o_ml),
        .o_minutes_right (o_mr),
`ifdef SECONDS_OUT_EN
        .o_seconds_left  (o_sl),
        .o_seconds_right (o_sr),
`endif
        .sec_tick        (sec_tick),
        .min_tick        (min_tick),
        .day_tick        (day_tick),
        .load_err        (load_err)
    );

    always #5 clk = ~clk;

    assign w_hhmm = {o_hl, o_hr, o_ml, o_mr};

    function automatic logic [12:0] hhmm(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sec_tick) n_sec++;
            if (min_tick) n_min++;
            if (day_tick) n_day++;
            if (sec_tick && min_tick && day_tick) n_all++;
        end
    endtask

    task automatic clear_counts();
        n_sec = 0; n_min = 0; n_day = 0; n_all = 0;
    endtask

    task automatic do_load(input int h, input int m);
        load_en = 1'b1;
        i_hl = 2'(h / 10); i_hr = 4'(h % 10); i_ml = 3'(m / 10); i_mr = 4'(m % 10);
        step(1);
        load_en = 1'b0;
        clear_counts();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(3);
        n_tests++;
        if (w_hhmm !== 13'd0) begin n_fail++; $display("FAIL reset_digits: got %h, expected %h", w_hhmm, 13'd0); end
        n_tests++;
        if ({sec_tick, min_tick, day_tick, load_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b, expected 0000", {sec_tick, min_tick, day_tick, load_err});
        end
    endtask

    task automatic test_count();
        rst = 1'b1;
        clear_counts();
        step(3);
        n_tests++;
        if (n_sec !== 0) begin n_fail++; $display("FAIL early_tick: got %0d, expected 0", n_sec); end
        step(1);
        n_tests++;
        if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL first_tick: got %b, expected 1", sec_tick); end
        step(956);
        n_tests++;
        if (w_hhmm !== hhmm(0, 4)) begin n_fail++; $display("FAIL count_240: got %h, expected %h", w_hhmm, hhmm(0, 4)); end
        n_tests++;
        if (n_sec !== 240) begin n_fail++; $display("FAIL sec_ticks: got %0d, expected 240", n_sec); end
        n_tests++;
        if (n_min !== 4) begin n_fail++; $display("FAIL min_ticks: got %0d, expected 4", n_min); end
        n_tests++;
        if (n_day !== 0) begin n_fail++; $display("FAIL day_ticks_none: got %0d, expected 0", n_day); end
    endtask

    task automatic test_day_wrap();
        do_load(23, 59);
        n_tests++;
        if (w_hhmm !== hhmm(23, 59)) begin n_fail++; $display("FAIL load_2359: got %h, expected %h", w_hhmm, hhmm(23, 59)); end
        step(240);
        n_tests++;
        if (w_hhmm !== 13'd0) begin n_fail++; $display("FAIL day_wrap: got %h, expected %h", w_hhmm, 13'd0); end
        n_tests++;
        if (n_day !== 1 || n_min !== 1 || n_sec !== 60) begin
            n_fail++; $display("FAIL wrap_ticks: got day=%0d min=%0d sec=%0d, expected 1 1 60", n_day, n_min, n_sec);
        end
        n_tests++;
        if (n_all !== 1) begin n_fail++; $display("FAIL wrap_coincident: got %0d, expected 1", n_all); end
    endtask

    task automatic test_hour_carry();
        do_load(19, 59);
        step(240);
        n_tests++;
        if (w_hhmm !== hhmm(20, 0)) begin n_fail++; $display("FAIL carry_19_20: got %h, expected %h", w_hhmm, hhmm(20, 0)); end
        do_load(9, 59);
        step(240);
        n_tests++;
        if (w_hhmm !== hhmm(10, 0)) begin n_fail++; $display("FAIL carry_09_10: got %h, expected %h", w_hhmm, hhmm(10, 0)); end
        n_tests++;
        if (n_day !== 0 || n_min !== 1) begin
            n_fail++; $display("FAIL carry_ticks: got day=%0d min=%0d, expected 0 1", n_day, n_min);
        end
    endtask

    task automatic test_invalid_load();
        logic [12:0] bad [5];
        bad[0] = {2'd2, 4'd4, 3'd0, 4'd0};
        bad[1] = {2'd3, 4'd0, 3'd0, 4'd0};
        bad[2] = {2'd1, 4'd10, 3'd0, 4'd0};
        bad[3] = {2'd1, 4'd2, 3'd6, 4'd0};
        bad[4] = {2'd1, 4'd2, 3'd3, 4'd10};
        do_load(12, 34);
        step(40);
        for (int v = 0; v < 5; v++) begin
            load_en = 1'b1;
            {i_hl, i_hr, i_ml, i_mr} = bad[v];
            step(1);
            n_tests++;
            if (load_err !== 1'b1) begin n_fail++; $display("FAIL load_err_set[%0d]: got %b, expected 1", v, load_err); end
            n_tests++;
            if (w_hhmm !== hhmm(12, 34)) begin n_fail++; $display("FAIL invalid_kept[%0d]: got %h, expected %h", v, w_hhmm, hhmm(12, 34)); end
            load_en = 1'b0;
            clear_counts();
            step(3);
            n_tests++;
            if (load_err !== 1'b0 || n_sec !== 0) begin
                n_fail++; $display("FAIL post_invalid[%0d]: got err=%b ticks=%0d, expected 0 0", v, load_err, n_sec);
            end
            step(1);
            n_tests++;
            if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL resume_tick[%0d]: got %b, expected 1", v, sec_tick); end
        end
    endtask

    task automatic test_pause();
        step(2);
        pause = 1'b1;
        clear_counts();
        step(10);
        n_tests++;
        if (n_sec !== 0 || w_hhmm !== hhmm(12, 34)) begin
            n_fail++; $display("FAIL pause_hold: got ticks=%0d hhmm=%h, expected 0 %h", n_sec, w_hhmm, hhmm(12, 34));
        end
        pause = 1'b0;
        step(1);
        n_tests++;
        if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL pause_early: got %b, expected 0", sec_tick); end
        step(1);
        n_tests++;
        if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL pause_resume: got %b, expected 1", sec_tick); end
    endtask

    task automatic test_load_tc_and_reset();
        step(3);
        do_load(8, 15);
        n_tests++;
        if (w_hhmm !== hhmm(8, 15) || sec_tick !== 1'b0) begin
            n_fail++; $display("FAIL load_on_tc: got hhmm=%h tick=%b, expected %h 0", w_hhmm, sec_tick, hhmm(8, 15));
        end
`ifdef SECONDS_OUT_EN
        n_tests++;
        if ({o_sl, o_sr} !== 7'd0) begin n_fail++; $display("FAIL load_secs: got %h, expected 00", {o_sl, o_sr}); end
`endif
        step(4);
        n_tests++;
        if (sec_tick !== 1'b1 || n_sec !== 1) begin
            n_fail++; $display("FAIL after_load_tick: got tick=%b count=%0d, expected 1 1", sec_tick, n_sec);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (w_hhmm !== 13'd0 || sec_tick !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got hhmm=%h tick=%b, expected 0 0", w_hhmm, sec_tick);
        end
        step(1);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_count();
        test_day_wrap();
        test_hour_carry();
        test_invalid_load();
        test_pause();
        test_load_tc_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/time_counter.md
# time_counter

Free-running time-of-day counter that sits directly downstream of the time-setting stage. It holds the current time as BCD digits (HH:MM:SS, 24-hour). It advances once per second from a parameterised clock prescaler. It loads the user-entered HH:MM digits when the setting stage asserts its "set time active" output, and its digit outputs feed the display driver.

## Interface
- TICKS_PER_SEC, 50_000_000: clk cycles per second; must be ≥ 2. Prescaler width is $clog2(TICKS_PER_SEC).
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- load_en  in  1  level load request; driven by the setting stage's set_time_active
- pause  in  1  freeze counting while the user is editing; driven by set_time_en
- i_hours_left  in  2  loaded tens-of-hours digit, 0–2
- i_hours_right  in  4  loaded units-of-hours digit, 0–9
- i_minutes_left  in  3  loaded tens-of-minutes digit, 0–5
- i_minutes_right  in  4  loaded units-of-minutes digit, 0–9
- o_hours_left  out  2  current tens of hours
- o_hours_right  out  4  current units of hours
- o_minutes_left  out  3  current tens of minutes
- o_minutes_right  out  4  current units of minutes
- o_seconds_left  out  3  current tens of seconds (only with SECONDS_OUT_EN)
- o_seconds_right  out  4  current units of seconds (only with SECONDS_OUT_EN)
- sec_tick  out  1  one-cycle pulse on each seconds increment
- min_tick  out  1  one-cycle pulse when seconds wrap 59→00
- day_tick  out  1  one-cycle pulse when time wraps 23:59:59→00:00:00
- load_err  out  1  registered; high for one cycle after an out-of-range load was rejected

## Operation
- Reset:
  - all digits 0 (00:00:00);
  - prescaler 0;
  - sec_tick, min_tick, day_tick and load_err all 0.
- Priority, highest first: load_en, then pause, then counting.
- Load (load_en=1):
  - Validity check on the input digits:
    - hours ≤ 23, i.e. if left = 2 then right ≤ 3;
    - left hours ≤ 2;
    - right hours ≤ 9;
    - left minutes ≤ 5;
    - right minutes ≤ 9.
  - Valid load: on each clock edge, minutes and hours take the input digits, seconds are cleared to 00 and the prescaler is cleared to 0. Load is level-sensitive, so a held load_en keeps reloading.
  - Invalid load: the registers are unchanged, the prescaler is cleared, and load_err=1 on the next cycle.
  - No ticks are generated while load_en=1.
- Pause (pause=1, load_en=0): prescaler and digits hold; no ticks.
- Counting:
  - The prescaler increments every cycle.
  - At TICKS_PER_SEC-1 the prescaler wraps to 0 and the seconds digits advance.
- BCD cascade, all applied in the same edge:
  - units digit 9→0 carries into the tens digit;
  - seconds 59→00 carries into minutes;
  - minutes 59→00 carries into hours;
  - hours 23→00 raises day_tick.
  - Hours units wrap at 9 when hours-left < 2, and at 3 when hours-left = 2.
- Ticks are registered and asserted for exactly the cycle after the digit update edge. min_tick is coincident with sec_tick; day_tick is coincident with both.

## Timing
- After reset release, or after the falling edge of load_en, the first seconds increment occurs on the TICKS_PER_SEC-th rising edge.
- Digit outputs are registered with zero extra latency: they update on the terminal-count edge.
- pause does not reset the prescaler. After pause deasserts, the count resumes from its held value, so there is no partial-second loss beyond the paused cycles.
- load_en and terminal count on the same cycle: load wins, and no tick is generated.
- Reset mid-operation: immediate asynchronous clear to 00:00:00; a pending tick is dropped.
- The inputs are synchronous to clk because the setting stage shares the clock; no input synchronisers are required.

## Configuration
- SECONDS_OUT_EN defined:
  - the o_seconds_left and o_seconds_right ports exist and are driven from the seconds registers.
- SECONDS_OUT_EN undefined:
  - both seconds ports are absent;
  - seconds are still counted internally;
  - sec_tick, min_tick, day_tick and all cascade behaviour are identical to the defined case.

## Structure
- Shared package clock_pkg holds:
  - the digit width constants: HL_W=2, HR_W=4, ML_W=3, MR_W=4;
  - the digit limit constants: MAX_TENS_MIN_SEC=5, MAX_UNITS=9, MAX_TENS_HOUR=2, MAX_UNITS_HOUR_AT_20=3.
  The setting stage reuses these constants.
- Sub-module tick_gen: the prescaler, with inputs clr and hold and a terminal-count pulse output; parameterised by TICKS_PER_SEC.
- Cascade logic and load validation live in time_counter itself.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset release, no load → output 00:00:00. Increments at 4-cycle intervals; after 240 ticks the output is 00:04:00, and min_tick has pulsed 4 times.
- Load 23:59 for 1 cycle, then run 60 seconds → the time wraps to 00:00:00. day_tick, min_tick and sec_tick pulse together exactly once.
- Load 19:59 and run 60 seconds → the output is 20:00. Load 09:59 and run 60 seconds → the output is 10:00.
- Load 24:00 (invalid) while the counter shows 12:34:10 → the counter is unchanged, load_err=1 for one cycle, and the next increment comes 4 cycles after load_en falls.
- pause held for 10 cycles with the prescaler at 2 → no digit change and no ticks. After release, the next increment arrives 2 cycles later.
- load_en asserted on a terminal-count cycle with input 08:15 → the output is 08:15:00 and no sec_tick is generated. Reset asserted mid-count → immediate return to 00:00:00.
